// File: rtl/serial_magnitude_comparator_if.sv
// Start/ready request bus and registered result bus of the digit-serial comparator.
// The master side drives the request and the slave side returns the result.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             agb;
    logic             alb;
    logic             aeb;
    logic [CW-1:0]    digits_used;

    modport master (
        output start, is_signed, a, b,
        input  ready, done, agb, alb, aeb, digits_used
    );

    modport slave (
        input  start, is_signed, a, b,
        output ready, done, agb, alb, aeb, digits_used
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: walks two operands MSB-first, DIGIT bits per clock,
// and stops at the first differing digit. Signed mode uses offset-binary (MSB flipped).
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input logic clk,
    input logic rst,
    serial_magnitude_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
    localparam logic [CW-1:0] FULL = CW'(NDIG);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    k_q, k_d;
    logic             agb_q, agb_d;
    logic             alb_q, alb_d;
    logic             aeb_q, aeb_d;
    logic [CW-1:0]    du_q, du_d;
    logic [WIDTH-1:0] load_a, load_b;
    logic [DIGIT-1:0] dig_a, dig_b;

    assign dig_a = sa_q[WIDTH-1 -: DIGIT];
    assign dig_b = sb_q[WIDTH-1 -: DIGIT];

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        load_a = bus.a;
        load_b = bus.b;
        load_a[WIDTH-1] = bus.a[WIDTH-1] ^ bus.is_signed;
        load_b[WIDTH-1] = bus.b[WIDTH-1] ^ bus.is_signed;
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        k_d     = k_q;
        agb_d   = agb_q;
        alb_d   = alb_q;
        aeb_d   = aeb_q;
        du_d    = du_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = load_a;
                    sb_d    = load_b;
                    k_d     = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (dig_a != dig_b) begin
                    agb_d   = (dig_a > dig_b);
                    alb_d   = (dig_a < dig_b);
                    aeb_d   = 1'b0;
                    du_d    = k_q + CW'(1);
                    state_d = DONE;
                end else if (k_q == LAST) begin
                    agb_d   = 1'b0;
                    alb_d   = 1'b0;
                    aeb_d   = 1'b1;
                    du_d    = FULL;
                    state_d = DONE;
                end else begin
                    sa_d = sa_q << DIGIT;
                    sb_d = sb_q << DIGIT;
                    k_d  = k_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            k_q     <= '0;
            agb_q   <= 1'b0;
            alb_q   <= 1'b0;
            aeb_q   <= 1'b0;
            du_q    <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            k_q     <= k_d;
            agb_q   <= agb_d;
            alb_q   <= alb_d;
            aeb_q   <= aeb_d;
            du_q    <= du_d;
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.agb         = agb_q;
    assign bus.alb         = alb_q;
    assign bus.aeb         = aeb_q;
    assign bus.digits_used = du_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Drives a 4-bit-digit and a single-digit comparator with the same requests and checks
// results, digit counts and latency against an arithmetic reference model.
module tb_serial_magnitude_comparator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        is_signed;
    logic [15:0] a;
    logic [15:0] b;
    int          checks   = 0;
    int          failures = 0;

    serial_magnitude_comparator_if #(.WIDTH(16), .DIGIT(4))  bus4 ();
    serial_magnitude_comparator_if #(.WIDTH(16), .DIGIT(16)) bus16 ();

    assign bus4.start      = start;
    assign bus4.is_signed  = is_signed;
    assign bus4.a          = a;
    assign bus4.b          = b;
    assign bus16.start     = start;
    assign bus16.is_signed = is_signed;
    assign bus16.a         = a;
    assign bus16.b         = b;

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result as {agb, alb, aeb} from integer order; digit count from the first raw digit that differs.
    function automatic void refModel(input logic [15:0] x, input logic [15:0] y, input logic sgn,
                                     input int dig, output logic [2:0] res, output int du);
        int xv, yv, nd, mask, sh;
        bit found;
        xv = sgn ? int'($signed(x)) : int'(x);
        yv = sgn ? int'($signed(y)) : int'(y);
        res = (xv > yv) ? 3'b100 : ((xv < yv) ? 3'b010 : 3'b001);
        nd = 16 / dig;
        du = nd;
        found = 1'b0;
        mask = (1 << dig) - 1;
        for (int i = 0; i < nd; i++) begin
            sh = 16 - (i + 1) * dig;
            if (!found && (((int'(x) >> sh) & mask) != ((int'(y) >> sh) & mask))) begin
                du = i + 1;
                found = 1'b1;
            end
        end
    endfunction

    task automatic waitIdle();
        int n = 0;
        while (!(bus4.ready && bus16.ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tbv, input logic ts);
        logic [2:0] e4, e16, r4, r16;
        int du4, du16, lat4, lat16, d4o, d16o;
        refModel(ta, tbv, ts, 4, e4, du4);
        refModel(ta, tbv, ts, 16, e16, du16);
        waitIdle();
        a = ta;
        b = tbv;
        is_signed = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        is_signed = 1'($urandom);
        checkOutput("ready_after_accept", 32'(bus4.ready), 32'd0);
        lat4 = 0;
        lat16 = 0;
        r4 = 'x;
        r16 = 'x;
        d4o = -1;
        d16o = -1;
        for (int c = 1; c <= 40 && lat4 == 0; c++) begin
            @(negedge clk);
            if (bus16.done && lat16 == 0) begin
                lat16 = c;
                r16 = {bus16.agb, bus16.alb, bus16.aeb};
                d16o = int'(bus16.digits_used);
            end
            if (bus4.done) begin
                lat4 = c;
                r4 = {bus4.agb, bus4.alb, bus4.aeb};
                d4o = int'(bus4.digits_used);
            end
        end
        checkOutput("latency4", 32'(lat4), 32'(du4));
        checkOutput("result4", 32'(r4), 32'(e4));
        checkOutput("digits4", 32'(d4o), 32'(du4));
        checkOutput("latency16", 32'(lat16), 32'd1);
        checkOutput("result16", 32'(r16), 32'(e16));
        checkOutput("digits16", 32'(d16o), 32'(du16));
        @(negedge clk);
        checkOutput("done_single_cycle", 32'(bus4.done), 32'd0);
        checkOutput("ready_return", 32'(bus4.ready), 32'd1);
    endtask

    initial begin
        int accepts, dones, lowrun;
        logic [15:0] ra, rb;
        rst = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(bus4.ready), 32'd1);
        checkOutput("reset_done", 32'(bus4.done), 32'd0);
        checkOutput("reset_result", 32'({bus4.agb, bus4.alb, bus4.aeb}), 32'd0);
        checkOutput("reset_digits", 32'(bus4.digits_used), 32'd0);
        checkOutput("reset_result16", 32'({bus16.agb, bus16.alb, bus16.aeb}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h1235, 1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b0);
        applyStimulus(16'h8000, 16'h7FFF, 1'b1);
        applyStimulus(16'hFFFF, 16'hFFFE, 1'b1);
        applyStimulus(16'hABCD, 16'hABCD, 1'b0);
        applyStimulus(16'hABCD, 16'hABCD, 1'b1);
        applyStimulus(16'h0010, 16'h0100, 1'b0);

        // Start held high: only requests seen while ready are taken, one done each.
        waitIdle();
        a = 16'h0001;
        b = 16'h0000;
        is_signed = 1'b0;
        start = 1'b1;
        accepts = 0;
        dones = 0;
        lowrun = 0;
        for (int c = 0; c < 40; c++) begin
            if (start && bus4.ready) accepts++;
            @(negedge clk);
            if (bus4.done) dones++;
            if (!bus4.ready) lowrun++;
            else if (lowrun > 0) begin
                checkOutput("ready_low_run", 32'(lowrun), 32'd5);
                lowrun = 0;
            end
            if (c == 29) start = 1'b0;
        end
        checkOutput("accepts_held_start", 32'(accepts), 32'd5);
        checkOutput("dones_per_accept", 32'(dones), 32'(accepts));
        checkOutput("held_start_result", 32'({bus4.agb, bus4.alb, bus4.aeb}), 32'b100);

        // Reset in the middle of a four-digit compare.
        waitIdle();
        a = 16'h1234;
        b = 16'h1235;
        is_signed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_ready", 32'(bus4.ready), 32'd1);
        checkOutput("abort_done", 32'(bus4.done), 32'd0);
        checkOutput("abort_result", 32'({bus4.agb, bus4.alb, bus4.aeb}), 32'd0);
        checkOutput("abort_digits", 32'(bus4.digits_used), 32'd0);
        checkOutput("abort_result16", 32'({bus16.agb, bus16.alb, bus16.aeb}), 32'd0);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus4.done) dones++;
        end
        checkOutput("no_done_after_abort", 32'(dones), 32'd0);
        applyStimulus(16'h1234, 16'h1235, 1'b0);

        // Random operands, biased toward long shared prefixes.
        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom);
                1: rb = ra;
                2: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = ra ^ (16'($urandom) & 16'h00FF);
            endcase
            applyStimulus(ra, rb, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
